// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the ALU arbiter slice.
//   - ALU opcode constants understood by the downstream ALU
//   - ALU_DEFAULT: result the ALU returns for unsupported opcodes
//   - arb_state_e: arbiter FSM state encoding
package alu_pkg;

  localparam logic [3:0] ALU_AND = 4'd0;
  localparam logic [3:0] ALU_OR  = 4'd1;
  localparam logic [3:0] ALU_ADD = 4'd2;
  localparam logic [3:0] ALU_SUB = 4'd6;
  localparam logic [3:0] ALU_SLT = 4'd7;
  localparam logic [3:0] ALU_NOR = 4'd12;

  localparam int unsigned ALU_DEFAULT = 42;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_HOLD = 2'd2
  } arb_state_e;

endpackage

// File: rtl/rr_arbiter_2.sv
// rr_arbiter_2: two-way round-robin grant, purely combinational.
//   req_i        : request vector, bit i = requester i
//   last_grant_i : requester granted most recently
//   grant_o      : one-hot grant, zero when nothing is requested
module rr_arbiter_2 (
  input  logic [1:0] req_i,
  input  logic       last_grant_i,
  output logic [1:0] grant_o
);

  always_comb begin
    grant_o = '0;
    unique case (req_i)
      2'b01:   grant_o = 2'b01;
      2'b10:   grant_o = 2'b10;
      // Tie: favour whichever requester was not served last.
      2'b11:   grant_o = last_grant_i ? 2'b01 : 2'b10;
      default: grant_o = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two requesters.
//   Clock, Reset (async active-low)
//   Req_Valid/Req_Ready        : per-requester request handshake
//   Req_Control/Req_A/Req_B    : packed per-requester operands (req 0 in low slice)
//   Rsp_Valid/Rsp_Ready        : per-requester response handshake
//   Rsp_Result/Rsp_Zero        : captured ALU result, held until taken
//   Alu_Control/Input1/Input2  : registered operands driven to the ALU
//   Alu_Out/Alu_Zero           : ALU result returned to this block
// Sequence per operation: IDLE (accept) -> EXEC (ALU evaluates) -> HOLD
// (response waits for its owner).
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic [1:0]         Req_Valid,
  output logic [1:0]         Req_Ready,
  input  logic [7:0]         Req_Control,
  input  logic [2*WIDTH-1:0] Req_A,
  input  logic [2*WIDTH-1:0] Req_B,
  output logic [1:0]         Rsp_Valid,
  input  logic [1:0]         Rsp_Ready,
  output logic [WIDTH-1:0]   Rsp_Result,
  output logic               Rsp_Zero,
  output logic [3:0]         Alu_Control,
  output logic [WIDTH-1:0]   Alu_Input1,
  output logic [WIDTH-1:0]   Alu_Input2,
  input  logic [WIDTH-1:0]   Alu_Out,
  input  logic               Alu_Zero
);

  arb_state_e       state_q;
  logic             owner_q;
  logic             last_grant_q;
  logic [3:0]       ctrl_q;
  logic [WIDTH-1:0] in1_q;
  logic [WIDTH-1:0] in2_q;
  logic [1:0]       rsp_valid_q;
  logic [WIDTH-1:0] rsp_result_q;
  logic             rsp_zero_q;

  logic [1:0]       grant;
  logic             sel_d;
  logic [3:0]       ctrl_d;
  logic [WIDTH-1:0] in1_d;
  logic [WIDTH-1:0] in2_d;

  rr_arbiter_2 u_rr (
    .req_i        (Req_Valid),
    .last_grant_i (last_grant_q),
    .grant_o      (grant)
  );

  // Operand mux for the granted requester; only sampled in IDLE.
  always_comb begin
    sel_d  = grant[1];
    ctrl_d = sel_d ? Req_Control[7:4]      : Req_Control[3:0];
    in1_d  = sel_d ? Req_A[2*WIDTH-1:WIDTH] : Req_A[WIDTH-1:0];
    in2_d  = sel_d ? Req_B[2*WIDTH-1:WIDTH] : Req_B[WIDTH-1:0];
  end

  // Ready depends only on state, Req_Valid and Last_Grant.
  always_comb begin
    Req_Ready = (state_q == ST_IDLE) ? grant : '0;
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q      <= ST_IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      ctrl_q       <= '0;
      in1_q        <= '0;
      in2_q        <= '0;
      rsp_valid_q  <= '0;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (|Req_Valid) begin
            ctrl_q       <= ctrl_d;
            in1_q        <= in1_d;
            in2_q        <= in2_d;
            owner_q      <= sel_d;
            last_grant_q <= sel_d;
            state_q      <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          rsp_result_q <= Alu_Out;
          rsp_zero_q   <= Alu_Zero;
          rsp_valid_q  <= owner_q ? 2'b10 : 2'b01;
          state_q      <= ST_HOLD;
        end
        ST_HOLD: begin
          // Only the owner's Rsp_Ready completes the response.
          if (Rsp_Ready[owner_q]) begin
            rsp_valid_q <= '0;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign Alu_Control = ctrl_q;
  assign Alu_Input1  = in1_q;
  assign Alu_Input2  = in2_q;
  assign Rsp_Valid   = rsp_valid_q;
  assign Rsp_Result  = rsp_result_q;
  assign Rsp_Zero    = rsp_zero_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed scoreboard bench for alu_arbiter with a
// behavioural ALU attached to the ALU-side ports.
module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int unsigned W = 32;

  logic           clk;
  logic           rst_n;
  logic [1:0]     req_valid;
  logic [1:0]     req_ready;
  logic [7:0]     req_control;
  logic [2*W-1:0] req_a;
  logic [2*W-1:0] req_b;
  logic [1:0]     rsp_valid;
  logic [1:0]     rsp_ready;
  logic [W-1:0]   rsp_result;
  logic           rsp_zero;
  logic [3:0]     alu_control;
  logic [W-1:0]   alu_in1;
  logic [W-1:0]   alu_in2;
  logic [W-1:0]   alu_out;
  logic           alu_zero;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic         owner;
    logic [W-1:0] result;
    logic         zero;
  } exp_t;

  exp_t exp_q[$];

  alu_arbiter #(.WIDTH(W)) dut (
    .Clock       (clk),
    .Reset       (rst_n),
    .Req_Valid   (req_valid),
    .Req_Ready   (req_ready),
    .Req_Control (req_control),
    .Req_A       (req_a),
    .Req_B       (req_b),
    .Rsp_Valid   (rsp_valid),
    .Rsp_Ready   (rsp_ready),
    .Rsp_Result  (rsp_result),
    .Rsp_Zero    (rsp_zero),
    .Alu_Control (alu_control),
    .Alu_Input1  (alu_in1),
    .Alu_Input2  (alu_in2),
    .Alu_Out     (alu_out),
    .Alu_Zero    (alu_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU.
  always_comb begin
    alu_out = 32'd42;
    case (alu_control)
      ALU_AND: alu_out = alu_in1 & alu_in2;
      ALU_OR:  alu_out = alu_in1 | alu_in2;
      ALU_ADD: alu_out = alu_in1 + alu_in2;
      ALU_SUB: alu_out = alu_in1 - alu_in2;
      ALU_SLT: alu_out = ($signed(alu_in1) < $signed(alu_in2)) ? 32'd1 : 32'd0;
      ALU_NOR: alu_out = ~(alu_in1 | alu_in2);
      default: alu_out = 32'd42;
    endcase
    alu_zero = (alu_out == '0);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic owner, input logic [W-1:0] result, input logic zero);
    exp_t e;
    e.owner  = owner;
    e.result = result;
    e.zero   = zero;
    exp_q.push_back(e);
  endtask

  task automatic set_req(input int r, input logic [3:0] ctrl, input logic [W-1:0] a,
                         input logic [W-1:0] b);
    if (r == 0) begin
      req_control[3:0] = ctrl;
      req_a[W-1:0]     = a;
      req_b[W-1:0]     = b;
    end else begin
      req_control[7:4] = ctrl;
      req_a[2*W-1:W]   = a;
      req_b[2*W-1:W]   = b;
    end
    req_valid[r] = 1'b1;
  endtask

  // Waits for Req_Ready[r], lets the accepting edge pass, then drops valid.
  task automatic wait_accept(input int r);
    int n;
    n = 0;
    #1;
    while (!req_ready[r] && n < 40) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!req_ready[r]) begin
      errors++;
      checks++;
      $display("FAIL accept_timeout: req %0d never got Req_Ready", r);
    end
    @(posedge clk);
    #1;
    req_valid[r] = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    chk("drain_queue_empty", exp_q.size(), 0);
  endtask

  // Monitor: every response handshake is compared with the next expectation.
  initial begin
    exp_t e;
    logic owner;
    forever begin
      @(negedge clk);
      if (rst_n && rsp_valid != 2'b00) begin
        if (rsp_valid == 2'b11) chk("rsp_valid_onehot", {30'd0, rsp_valid}, 32'd1);
        owner = rsp_valid[1];
        if (rsp_ready[owner]) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_response", {31'd0, owner}, 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            chk("rsp_owner",  {31'd0, owner},    {31'd0, e.owner});
            chk("rsp_result", rsp_result,        e.result);
            chk("rsp_zero",   {31'd0, rsp_zero}, {31'd0, e.zero});
          end
        end
      end
    end
  end

  initial begin
    int n;
    rst_n       = 1'b0;
    req_valid   = '0;
    req_control = '0;
    req_a       = '0;
    req_b       = '0;
    rsp_ready   = 2'b11;
    #3;
    chk("reset_req_ready",   {30'd0, req_ready}, 0);
    chk("reset_rsp_valid",   {30'd0, rsp_valid}, 0);
    chk("reset_rsp_result",  rsp_result, 0);
    chk("reset_rsp_zero",    {31'd0, rsp_zero}, 0);
    chk("reset_alu_control", {28'd0, alu_control}, 0);
    chk("reset_alu_in1",     alu_in1, 0);
    chk("reset_alu_in2",     alu_in2, 0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Tie straight after reset: req 0 wins; req 0 re-requests at once, so
    // the next tie goes to req 1, then req 0 again.
    push_exp(1'b0, 32'h0000_00FF, 1'b0);
    push_exp(1'b1, 32'h0000_003C, 1'b0);
    push_exp(1'b0, 32'h0000_0030, 1'b0);
    set_req(0, ALU_OR,  32'hF0, 32'h0F);
    set_req(1, ALU_AND, 32'hFF, 32'h3C);
    #1;
    chk("tie_first_grant", {30'd0, req_ready}, 32'd1);
    wait_accept(0);
    set_req(0, ALU_ADD, 32'h10, 32'h20);
    wait_accept(1);
    wait_accept(0);
    drain();

    // Req 0 ADD 5+7: one-cycle latency, Alu_Control=2 in EXEC.
    push_exp(1'b0, 32'd12, 1'b0);
    set_req(0, ALU_ADD, 32'd5, 32'd7);
    #1;
    chk("add_req_ready", {30'd0, req_ready}, 32'd1);
    wait_accept(0);
    chk("exec_alu_control", {28'd0, alu_control}, 32'd2);
    chk("exec_alu_in1", alu_in1, 32'd5);
    chk("exec_alu_in2", alu_in2, 32'd7);
    chk("exec_req_ready", {30'd0, req_ready}, 0);
    chk("exec_rsp_valid", {30'd0, rsp_valid}, 0);
    @(posedge clk);
    #1;
    chk("latency_rsp_valid", {30'd0, rsp_valid}, 32'd1);
    drain();

    // Req 1 SUB 9-9: zero flag, and req 0 never sees a response.
    push_exp(1'b1, 32'd0, 1'b1);
    set_req(1, ALU_SUB, 32'd9, 32'd9);
    wait_accept(1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("sub_rsp0_quiet", {31'd0, rsp_valid[0]}, 0);
    end
    drain();

    // Stall the owner's Rsp_Ready; req 1 must wait.
    rsp_ready = 2'b10;
    push_exp(1'b0, 32'hFFFF_FFFF, 1'b0);
    set_req(0, ALU_NOR, 32'd0, 32'd0);
    wait_accept(0);
    push_exp(1'b1, 32'd1, 1'b0);
    set_req(1, ALU_SLT, 32'd3, 32'd5);
    n = 0;
    @(negedge clk);
    while (!rsp_valid[0] && n < 20) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      chk("stall_rsp_valid",  {30'd0, rsp_valid}, 32'd1);
      chk("stall_rsp_result", rsp_result, 32'hFFFF_FFFF);
      chk("stall_req_ready",  {30'd0, req_ready}, 0);
      @(negedge clk);
    end
    @(posedge clk);
    #1 rsp_ready = 2'b11;
    wait_accept(1);
    drain();

    // Reset during EXEC discards the operation.
    set_req(0, ALU_ADD, 32'd1, 32'd1);
    wait_accept(0);
    rst_n = 1'b0;
    #1;
    chk("midreset_req_ready",   {30'd0, req_ready}, 0);
    chk("midreset_rsp_valid",   {30'd0, rsp_valid}, 0);
    chk("midreset_rsp_result",  rsp_result, 0);
    chk("midreset_rsp_zero",    {31'd0, rsp_zero}, 0);
    chk("midreset_alu_control", {28'd0, alu_control}, 0);
    chk("midreset_alu_in1",     alu_in1, 0);
    chk("midreset_alu_in2",     alu_in2, 0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("postreset_no_rsp", {30'd0, rsp_valid}, 0);
    #1;

    // Unsupported opcode 3 returns the ALU default.
    push_exp(1'b0, 32'd42, 1'b0);
    set_req(0, 4'd3, 32'd1, 32'd2);
    #1;
    chk("postreset_idle_grant", {30'd0, req_ready}, 32'd1);
    wait_accept(0);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

endmodule
